// File: rtl/load_store_unit_if.sv
// Bus bundles around the load/store unit.
// lsu_core_if carries the execute-stage request/response handshake:
// the core is the master and the load/store unit is the slave.
// lsu_mem_if carries the data-memory access strobe and its acknowledge:
// the load/store unit is the master and the data memory is the slave.

interface lsu_core_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic [1:0]        resp_err;
    logic              busy;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

interface lsu_mem_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN/8-1:0] mem_be;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_ack;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_err;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata, mem_err
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata, mem_err
    );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory access unit between the execute stage and the data memory.
// A registered IDLE/REQ/RESP machine steers byte lanes and byte enables for
// stores, sign/zero-extends loads, rejects misaligned or illegal-size
// accesses without touching memory, reports bus errors and gives up on a
// silent memory after TIMEOUT request cycles (TIMEOUT=0 waits forever).

module load_store_unit #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic        clk,
    input logic        rst,
    lsu_core_if.slave  core,
    lsu_mem_if.master  mem
);
    localparam int BE_W       = XLEN / 8;
    localparam int OFF_W      = $clog2(BE_W);
    localparam int CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int CNT_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_LAST_I[CNT_W-1:0];
    localparam bit   TO_EN = (TIMEOUT != 0);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state_r, next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              req_ready_r, resp_valid_r;
    logic [XLEN-1:0]   resp_rdata_r;
    logic [1:0]        resp_err_r;
    logic              mem_req_r, mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [BE_W-1:0]   mem_be_r;
    logic [XLEN-1:0]   mem_wdata_r;
    logic [1:0]        size_r;
    logic              zext_r, write_r;
    logic [OFF_W-1:0]  off_r;

    logic              accept_s, illegal_s, misalign_s, reject_s;
    logic [2:0]        align_mask_s;
    logic [3:0]        nbytes_s, ld_nbytes_s;
    logic [OFF_W-1:0]  req_off_s;
    logic [BE_W-1:0]   be_base_s, be_s;
    logic [XLEN-1:0]   wdata_s, shifted_s, low_mask_s, ext_s;
    logic              sign_s, ack_s, timeout_s;

    assign accept_s    = core.req_valid & req_ready_r & (state_r == IDLE);
    assign req_off_s   = core.req_addr[OFF_W-1:0];
    assign nbytes_s    = 4'd1 << core.req_funct3[1:0];
    assign be_base_s   = ~({BE_W{1'b1}} << nbytes_s);
    assign be_s        = be_base_s << req_off_s;
    assign wdata_s     = core.req_wdata << {req_off_s, 3'b000};
    assign misalign_s  = (core.req_addr[2:0] & align_mask_s) != 3'b000;
    assign reject_s    = illegal_s | misalign_s;

    assign shifted_s   = mem.mem_rdata >> {off_r, 3'b000};
    assign ld_nbytes_s = 4'd1 << size_r;
    assign low_mask_s  = ~({XLEN{1'b1}} << {ld_nbytes_s, 3'b000});
    assign ack_s       = (state_r == REQ) & mem.mem_ack;
    assign timeout_s   = TO_EN & (state_r == REQ) & ~mem.mem_ack & (cnt_r == CNT_LAST);

    // Size legality: doubles only exist at XLEN=64, stores are never unsigned.
    always_comb begin
        illegal_s = 1'b0;
        if (core.req_write && core.req_funct3[2]) begin
            illegal_s = 1'b1;
        end else if (core.req_funct3 == 3'b111) begin
            illegal_s = 1'b1;
        end else if ((XLEN == 32) && ((core.req_funct3 == 3'b011) || (core.req_funct3 == 3'b110))) begin
            illegal_s = 1'b1;
        end else begin
            illegal_s = 1'b0;
        end
    end

    // Low address bits that must be zero for a naturally aligned access.
    always_comb begin
        align_mask_s = 3'b000;
        case (core.req_funct3[1:0])
            2'd0:    align_mask_s = 3'b000;
            2'd1:    align_mask_s = 3'b001;
            2'd2:    align_mask_s = 3'b011;
            2'd3:    align_mask_s = 3'b111;
            default: align_mask_s = 3'b111;
        endcase
    end

    // Sign bit of the loaded item and the final sign/zero extension.
    always_comb begin
        sign_s = 1'b0;
        ext_s  = shifted_s & low_mask_s;
        case (size_r)
            2'd0:    sign_s = shifted_s[7];
            2'd1:    sign_s = shifted_s[15];
            2'd2:    sign_s = shifted_s[31];
            default: sign_s = shifted_s[XLEN-1];
        endcase
        if (!zext_r && sign_s) begin
            ext_s = (shifted_s & low_mask_s) | ~low_mask_s;
        end else begin
            ext_s = shifted_s & low_mask_s;
        end
    end

    // Next-state logic; an ack in the last allowed cycle beats the timeout.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_s = reject_s ? RESP : REQ;
                end else begin
                    next_s = IDLE;
                end
            end
            REQ: begin
                if (ack_s || timeout_s) begin
                    next_s = RESP;
                end else begin
                    next_s = REQ;
                end
            end
            RESP:    next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // State register and the wait counter for the REQ phase.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= next_s;
            if (state_r != REQ) begin
                cnt_r <= '0;
            end else if (!mem.mem_ack) begin
                cnt_r <= cnt_r + CNT_W'(1'b1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Handshake flags registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_ready_r  <= 1'b0;
            resp_valid_r <= 1'b0;
            mem_req_r    <= 1'b0;
        end else begin
            req_ready_r  <= (next_s == IDLE);
            resp_valid_r <= (next_s == RESP);
            mem_req_r    <= (next_s == REQ);
        end
    end

    // Request fields needed to steer the returning load data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            size_r  <= 2'd0;
            zext_r  <= 1'b0;
            write_r <= 1'b0;
            off_r   <= '0;
        end else if (accept_s) begin
            size_r  <= core.req_funct3[1:0];
            zext_r  <= core.req_funct3[2];
            write_r <= core.req_write;
            off_r   <= req_off_s;
        end else begin
            size_r  <= size_r;
            zext_r  <= zext_r;
            write_r <= write_r;
            off_r   <= off_r;
        end
    end

    // Memory-side outputs: loaded on a legal accept, frozen through REQ, zero otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_be_r    <= '0;
            mem_wdata_r <= '0;
        end else if (accept_s && !reject_s) begin
            mem_we_r    <= core.req_write;
            mem_addr_r  <= {core.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_be_r    <= be_s;
            mem_wdata_r <= wdata_s;
        end else if (next_s == REQ) begin
            mem_we_r    <= mem_we_r;
            mem_addr_r  <= mem_addr_r;
            mem_be_r    <= mem_be_r;
            mem_wdata_r <= mem_wdata_r;
        end else begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_be_r    <= '0;
            mem_wdata_r <= '0;
        end
    end

    // Response payload, updated only when a response is being produced.
    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_rdata_r <= '0;
            resp_err_r   <= 2'b00;
        end else if (accept_s && reject_s) begin
            resp_rdata_r <= '0;
            resp_err_r   <= 2'b01;
        end else if (ack_s) begin
            resp_rdata_r <= (write_r || mem.mem_err) ? '0 : ext_s;
            resp_err_r   <= mem.mem_err ? 2'b10 : 2'b00;
        end else if (timeout_s) begin
            resp_rdata_r <= '0;
            resp_err_r   <= 2'b11;
        end else begin
            resp_rdata_r <= resp_rdata_r;
            resp_err_r   <= resp_err_r;
        end
    end

    assign core.req_ready  = req_ready_r;
    assign core.resp_valid = resp_valid_r;
    assign core.resp_rdata = resp_rdata_r;
    assign core.resp_err   = resp_err_r;
    assign core.busy       = (state_r != IDLE);
    assign mem.mem_req     = mem_req_r;
    assign mem.mem_we      = mem_we_r;
    assign mem.mem_addr    = mem_addr_r;
    assign mem.mem_be      = mem_be_r;
    assign mem.mem_wdata   = mem_wdata_r;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: an XLEN=32 instance with TIMEOUT=4 and
// an XLEN=64 instance with TIMEOUT=16, driven from a vector table plus
// hand-written timeout, stray-ack and reset sequences.

module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    lsu_core_if #(.XLEN(32), .ADDR_W(32)) c32 ();
    lsu_mem_if  #(.XLEN(32), .ADDR_W(32)) m32 ();
    lsu_core_if #(.XLEN(64), .ADDR_W(32)) c64 ();
    lsu_mem_if  #(.XLEN(64), .ADDR_W(32)) m64 ();

    load_store_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
        .clk(clk), .rst(rst), .core(c32), .mem(m32));
    load_store_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT(16)) dut64 (
        .clk(clk), .rst(rst), .core(c64), .mem(m64));

    typedef struct {
        string       name;
        bit          x64;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [63:0] wdata;
        int          ack_n;   // REQ cycle carrying the ack, 0 = never
        bit          merr;
        logic [63:0] rdata;
        logic [1:0]  e_err;
        logic [63:0] e_rdata;
        logic [31:0] e_addr;
        logic [7:0]  e_be;
        bit          e_we;
        logic [63:0] e_wdata;
        int          e_lat;   // cycles from accept edge to resp_valid
        int          e_reqc;  // cycles with mem_req high
    } vec_t;

    typedef struct {
        logic        req_ready, resp_valid, busy, mem_req, mem_we;
        logic [31:0] mem_addr;
        logic [7:0]  mem_be;
        logic [63:0] mem_wdata, resp_rdata;
        logic [1:0]  resp_err;
    } obs_t;

    vec_t tbl[$];

    function automatic vec_t mk(string name, bit x64, bit wr, logic [2:0] f3,
                                logic [31:0] addr, logic [63:0] wdata, int ack_n,
                                bit merr, logic [63:0] rdata, logic [1:0] e_err,
                                logic [63:0] e_rdata, logic [31:0] e_addr,
                                logic [7:0] e_be, bit e_we, logic [63:0] e_wdata,
                                int e_lat, int e_reqc);
        vec_t v;
        v.name = name; v.x64 = x64; v.wr = wr; v.f3 = f3; v.addr = addr;
        v.wdata = wdata; v.ack_n = ack_n; v.merr = merr; v.rdata = rdata;
        v.e_err = e_err; v.e_rdata = e_rdata; v.e_addr = e_addr; v.e_be = e_be;
        v.e_we = e_we; v.e_wdata = e_wdata; v.e_lat = e_lat; v.e_reqc = e_reqc;
        return v;
    endfunction

    function automatic obs_t sample(bit x64);
        obs_t o;
        if (x64) begin
            o.req_ready = c64.req_ready; o.resp_valid = c64.resp_valid;
            o.busy = c64.busy; o.mem_req = m64.mem_req; o.mem_we = m64.mem_we;
            o.mem_addr = m64.mem_addr; o.mem_be = m64.mem_be;
            o.mem_wdata = m64.mem_wdata; o.resp_rdata = c64.resp_rdata;
            o.resp_err = c64.resp_err;
        end else begin
            o.req_ready = c32.req_ready; o.resp_valid = c32.resp_valid;
            o.busy = c32.busy; o.mem_req = m32.mem_req; o.mem_we = m32.mem_we;
            o.mem_addr = m32.mem_addr; o.mem_be = {4'h0, m32.mem_be};
            o.mem_wdata = {32'h0, m32.mem_wdata}; o.resp_rdata = {32'h0, c32.resp_rdata};
            o.resp_err = c32.resp_err;
        end
        return o;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_req(bit x64, bit valid, bit wr, logic [2:0] f3,
                             logic [31:0] addr, logic [63:0] wd);
        if (x64) begin
            c64.req_valid = valid; c64.req_write = wr; c64.req_funct3 = f3;
            c64.req_addr = addr; c64.req_wdata = wd;
        end else begin
            c32.req_valid = valid; c32.req_write = wr; c32.req_funct3 = f3;
            c32.req_addr = addr; c32.req_wdata = wd[31:0];
        end
    endtask

    task automatic drive_mem(bit x64, bit ack, bit err, logic [63:0] rd);
        if (x64) begin
            m64.mem_ack = ack; m64.mem_err = err; m64.mem_rdata = rd;
        end else begin
            m32.mem_ack = ack; m32.mem_err = err; m32.mem_rdata = rd[31:0];
        end
    endtask

    // One access: wait for ready, issue, act as memory, check everything.
    task automatic run_vec(input vec_t v);
        obs_t o;
        int   waitc, cyc, reqc;
        bit   got, seen;
        waitc = 0;
        @(negedge clk); o = sample(v.x64);
        while (!o.req_ready && waitc < 20) begin
            @(negedge clk); o = sample(v.x64); waitc++;
        end
        if (!o.req_ready) chk({v.name, ".ready_wait"}, 64'd0, 64'd1);
        drive_req(v.x64, 1'b1, v.wr, v.f3, v.addr, v.wdata);
        @(posedge clk); #1;
        drive_req(v.x64, 1'b0, 1'b0, 3'b000, 32'h0, 64'h0);
        cyc = 0; reqc = 0; got = 1'b0; seen = 1'b0;
        while (!got && cyc < 30) begin
            @(negedge clk); cyc++; o = sample(v.x64);
            if (o.mem_req) begin
                reqc++;
                if (!seen) begin
                    seen = 1'b1;
                    chk({v.name, ".mem_addr"},  {32'h0, o.mem_addr}, {32'h0, v.e_addr});
                    chk({v.name, ".mem_be"},    {56'h0, o.mem_be},   {56'h0, v.e_be});
                    chk({v.name, ".mem_we"},    {63'h0, o.mem_we},   {63'h0, v.e_we});
                    chk({v.name, ".mem_wdata"}, o.mem_wdata,         v.e_wdata);
                end
            end
            if (o.mem_req && v.ack_n != 0 && reqc == v.ack_n)
                drive_mem(v.x64, 1'b1, v.merr, v.rdata);
            else
                drive_mem(v.x64, 1'b0, 1'b0, 64'h0);
            if (o.resp_valid) begin
                got = 1'b1;
                chk({v.name, ".resp_err"},   {62'h0, o.resp_err}, {62'h0, v.e_err});
                chk({v.name, ".resp_rdata"}, o.resp_rdata,        v.e_rdata);
                chk({v.name, ".latency"},    64'(cyc),            64'(v.e_lat));
                chk({v.name, ".req_cycles"}, 64'(reqc),           64'(v.e_reqc));
            end
        end
        if (!got) chk({v.name, ".resp_missing"}, 64'd0, 64'd1);
        @(negedge clk); o = sample(v.x64);
        chk({v.name, ".resp_one_cycle"}, {63'h0, o.resp_valid}, 64'd0);
        chk({v.name, ".ready_after"},    {63'h0, o.req_ready},  64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        vec_t tv;
        bit   stray;
        drive_req(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 64'h0);
        drive_req(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 64'h0);
        drive_mem(1'b0, 1'b0, 1'b0, 64'h0);
        drive_mem(1'b1, 1'b0, 1'b0, 64'h0);

        //       name       x64 wr f3      addr          wdata                  ack merr rdata                  err    e_rdata                e_addr        be     we e_wdata                lat reqc
        tbl.push_back(mk("LB",     0, 0, 3'b000, 32'h1003, 64'h0,                 1, 0, 64'h80FF_0000,         2'b00, 64'hFFFF_FF80,         32'h1000, 8'h08, 0, 64'h0,                 2, 1));
        tbl.push_back(mk("LBU",    0, 0, 3'b100, 32'h1003, 64'h0,                 1, 0, 64'h80FF_0000,         2'b00, 64'h0000_0080,         32'h1000, 8'h08, 0, 64'h0,                 2, 1));
        tbl.push_back(mk("SH",     0, 1, 3'b001, 32'h2002, 64'h0000_BEEF,         1, 0, 64'h1234_5678,         2'b00, 64'h0,                 32'h2000, 8'h0C, 1, 64'hBEEF_0000,         2, 1));
        tbl.push_back(mk("LW_mis", 0, 0, 3'b010, 32'h3002, 64'h0,                 1, 0, 64'h0,                 2'b01, 64'h0,                 32'h0,    8'h00, 0, 64'h0,                 1, 0));
        tbl.push_back(mk("LD_32",  0, 0, 3'b011, 32'h3000, 64'h0,                 1, 0, 64'h0,                 2'b01, 64'h0,                 32'h0,    8'h00, 0, 64'h0,                 1, 0));
        tbl.push_back(mk("LH_w3",  0, 0, 3'b001, 32'h4006, 64'h0,                 3, 0, 64'h8001_7FFF,         2'b00, 64'hFFFF_8001,         32'h4004, 8'h0C, 0, 64'h0,                 4, 3));
        tbl.push_back(mk("LHU",    0, 0, 3'b101, 32'h4004, 64'h0,                 1, 0, 64'h1234_9ABC,         2'b00, 64'h0000_9ABC,         32'h4004, 8'h03, 0, 64'h0,                 2, 1));
        tbl.push_back(mk("SW_w2",  0, 1, 3'b010, 32'h5000, 64'hDEAD_BEEF,         2, 0, 64'h0,                 2'b00, 64'h0,                 32'h5000, 8'h0F, 1, 64'hDEAD_BEEF,         3, 2));
        tbl.push_back(mk("SB",     0, 1, 3'b000, 32'h5001, 64'h0000_00A5,         1, 0, 64'h0,                 2'b00, 64'h0,                 32'h5000, 8'h02, 1, 64'h0000_A500,         2, 1));
        tbl.push_back(mk("SBU",    0, 1, 3'b100, 32'h5000, 64'h0,                 1, 0, 64'h0,                 2'b01, 64'h0,                 32'h0,    8'h00, 0, 64'h0,                 1, 0));
        tbl.push_back(mk("LWU_32", 0, 0, 3'b110, 32'h5000, 64'h0,                 1, 0, 64'h0,                 2'b01, 64'h0,                 32'h0,    8'h00, 0, 64'h0,                 1, 0));
        tbl.push_back(mk("LH_mis", 0, 0, 3'b001, 32'h1001, 64'h0,                 1, 0, 64'h0,                 2'b01, 64'h0,                 32'h0,    8'h00, 0, 64'h0,                 1, 0));
        tbl.push_back(mk("LD",     1, 0, 3'b011, 32'h0008, 64'h0,                 1, 0, 64'h8000_0000_0000_0001, 2'b00, 64'h8000_0000_0000_0001, 32'h0008, 8'hFF, 0, 64'h0,             2, 1));
        tbl.push_back(mk("LWU",    1, 0, 3'b110, 32'h000C, 64'h0,                 1, 0, 64'hF000_0000_0000_0000, 2'b00, 64'h0000_0000_F000_0000, 32'h0008, 8'hF0, 0, 64'h0,             2, 1));
        tbl.push_back(mk("LW_64",  1, 0, 3'b010, 32'h000C, 64'h0,                 1, 0, 64'hF000_0000_0000_0000, 2'b00, 64'hFFFF_FFFF_F000_0000, 32'h0008, 8'hF0, 0, 64'h0,             2, 1));
        tbl.push_back(mk("SD",     1, 1, 3'b011, 32'h0010, 64'h0123_4567_89AB_CDEF, 2, 0, 64'h0,               2'b00, 64'h0,                 32'h0010, 8'hFF, 1, 64'h0123_4567_89AB_CDEF, 3, 2));
        tbl.push_back(mk("LD_mis", 1, 0, 3'b011, 32'h0004, 64'h0,                 1, 0, 64'h0,                 2'b01, 64'h0,                 32'h0,    8'h00, 0, 64'h0,                 1, 0));
        tbl.push_back(mk("F3_111", 1, 0, 3'b111, 32'h0000, 64'h0,                 1, 0, 64'h0,                 2'b01, 64'h0,                 32'h0,    8'h00, 0, 64'h0,                 1, 0));

        // Reset state: everything low, including req_ready.
        repeat (3) @(posedge clk);
        @(negedge clk);
        o = sample(1'b0);
        chk("rst.req_ready",  {63'h0, o.req_ready},  64'd0);
        chk("rst.resp_valid", {63'h0, o.resp_valid}, 64'd0);
        chk("rst.busy",       {63'h0, o.busy},       64'd0);
        chk("rst.mem_req",    {63'h0, o.mem_req},    64'd0);
        chk("rst.resp_err",   {62'h0, o.resp_err},   64'd0);
        chk("rst.resp_rdata", o.resp_rdata,          64'd0);
        chk("rst.mem_be",     {56'h0, o.mem_be},     64'd0);
        o = sample(1'b1);
        chk("rst64.req_ready", {63'h0, o.req_ready}, 64'd0);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        o = sample(1'b0);
        chk("rst.ready_rise", {63'h0, o.req_ready}, 64'd1);

        foreach (tbl[i]) run_vec(tbl[i]);

        // Timeout with a silent memory, then a stray ack in IDLE.
        tv = mk("LW_tmo", 0, 0, 3'b010, 32'h6000, 64'h0, 0, 0, 64'h0, 2'b11, 64'h0,
                32'h6000, 8'h0F, 0, 64'h0, 5, 4);
        run_vec(tv);
        drive_mem(1'b0, 1'b1, 1'b0, 64'h55AA_55AA);
        stray = 1'b0;
        repeat (3) begin
            @(negedge clk); o = sample(1'b0);
            if (o.resp_valid || o.busy) stray = 1'b1;
        end
        drive_mem(1'b0, 1'b0, 1'b0, 64'h0);
        chk("stray_ack.no_resp", {63'h0, stray}, 64'd0);
        chk("stray_ack.err_held", {62'h0, o.resp_err}, 64'd3);

        // Bus error after the timeout.
        tv = mk("LW_berr", 0, 0, 3'b010, 32'h7000, 64'h0, 1, 1, 64'hFFFF_FFFF, 2'b10, 64'h0,
                32'h7000, 8'h0F, 0, 64'h0, 2, 1);
        run_vec(tv);

        // Reset during REQ abandons the access.
        @(negedge clk);
        drive_req(1'b0, 1'b1, 1'b0, 3'b010, 32'h6000, 64'h0);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 64'h0);
        @(negedge clk); o = sample(1'b0);
        chk("mid_rst.in_req", {63'h0, o.mem_req}, 64'd1);
        rst = 1'b0;
        @(posedge clk); @(negedge clk); o = sample(1'b0);
        chk("mid_rst.mem_req",    {63'h0, o.mem_req},    64'd0);
        chk("mid_rst.resp_valid", {63'h0, o.resp_valid}, 64'd0);
        chk("mid_rst.req_ready",  {63'h0, o.req_ready},  64'd0);
        rst = 1'b1;
        @(posedge clk); @(negedge clk); o = sample(1'b0);
        chk("mid_rst.ready_back", {63'h0, o.req_ready}, 64'd1);
        stray = 1'b0;
        repeat (8) begin
            @(negedge clk); o = sample(1'b0);
            if (o.resp_valid || o.mem_req) stray = 1'b1;
        end
        chk("mid_rst.no_resp", {63'h0, stray}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
